conv_window_scheduler: RTL

Sequencing controller for the convolution datapath: latches a layer configuration (input height/width, kernel size, stride, padding), then walks every output position and every kernel tap, emitting one input-coordinate request per tap over a valid/ready handshake to the MAC/line-buffer stage. It derives output dimensions by stepping window origins, so it needs no divider: it stops when origin + K exceeds IN + 2P. That gives OUT = (IN + 2P − K)/S + 1 for each axis.

---
 rtl/conv_window_scheduler_if.sv | 50 +++++
 rtl/conv_window_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler_if.sv
// Tap-request bus between the convolution window scheduler and the
// MAC/line-buffer stage, plus the layer control/status signals.
//
// Handshake: a tap transfers on a rising clk edge where tap_valid and
// tap_ready are both high. Once tap_valid is raised it stays high, and all
// tap_*/win_* fields stay stable, until that transfer happens. The only
// exceptions are abort and reset. tap_ready may toggle freely and never
// feeds back combinationally into tap_valid.
interface conv_window_scheduler_if #(
   parameter int DIM_W = 16
);
   logic                    start;
   logic                    abort;
   logic [DIM_W-1:0]        cfg_in_height;
   logic [DIM_W-1:0]        cfg_in_width;
   logic [DIM_W-1:0]        cfg_kernel_size;
   logic [DIM_W-1:0]        cfg_stride;
   logic [DIM_W-1:0]        cfg_padding;
   logic                    tap_valid;
   logic                    tap_ready;
   logic signed [DIM_W+1:0] tap_row;
   logic signed [DIM_W+1:0] tap_col;
   logic                    tap_pad;
   logic                    tap_first;
   logic                    tap_last;
   logic [DIM_W-1:0]        win_row;
   logic [DIM_W-1:0]        win_col;
   logic                    win_last;
   logic                    busy;
   logic                    done;
   logic                    cfg_error;
   logic [DIM_W-1:0]        out_height;
   logic [DIM_W-1:0]        out_width;

   modport master (
      output start, abort, cfg_in_height, cfg_in_width, cfg_kernel_size,
             cfg_stride, cfg_padding, tap_ready,
      input  tap_valid, tap_row, tap_col, tap_pad, tap_first, tap_last,
             win_row, win_col, win_last, busy, done, cfg_error,
             out_height, out_width
   );

   modport slave (
      input  start, abort, cfg_in_height, cfg_in_width, cfg_kernel_size,
             cfg_stride, cfg_padding, tap_ready,
      output tap_valid, tap_row, tap_col, tap_pad, tap_first, tap_last,
             win_row, win_col, win_last, busy, done, cfg_error,
             out_height, out_width
   );
endinterface

// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler: latches a layer configuration, checks it,
// then walks every output window and every kernel tap in order kx, ky,
// win_col, win_row, emitting one input coordinate per tap. Window origins
// are stepped by the stride until origin + K would pass IN + 2P, so no
// divider is needed. Optional macro CONV_SCHED_PERF_EN adds the perf_taps,
// perf_stalls and perf_pad counters.
module conv_window_scheduler #(
   parameter int DIM_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   conv_window_scheduler_if.slave bus,
   output logic [1:0]             dbg_state_o
`ifdef CONV_SCHED_PERF_EN
  ,output logic [31:0]            perf_taps,
   output logic [31:0]            perf_stalls,
   output logic [31:0]            perf_pad
`endif
);

   // Three extra bits keep origin + S + K free of overflow for any DIM_W inputs.
   localparam int CW = DIM_W + 3;
   typedef logic signed [CW-1:0] cmp_t;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

   function automatic cmp_t ext(input logic [DIM_W-1:0] v);
      return cmp_t'({3'b000, v});
   endfunction

   state_t                  state_q;
   logic [DIM_W-1:0]        h_q, w_q, k_q, s_q, p_q;
   cmp_t                    org_r_q, org_c_q;
   logic [DIM_W-1:0]        ky_q, kx_q, wr_q, wc_q, max_wc_q;
   logic                    tap_valid_q, pad_q, first_q, last_q, wlast_q;
   logic                    busy_q, done_q, err_q;
   logic signed [DIM_W+1:0] tap_row_q, tap_col_q;
   logic [DIM_W-1:0]        oh_q, ow_q;

   cmp_t                    h_x, w_x, k_x, s_x, p_x;
   logic                    kx_end, ky_end, col_ok, row_ok, final_tap, cfg_bad, hs;
   cmp_t                    org_r_d, org_c_d, row_d, col_d;
   logic [DIM_W-1:0]        ky_d, kx_d, wr_d, wc_d;
   logic                    pad_d, first_d, last_d, wlast_d;

   assign h_x = ext(h_q);
   assign w_x = ext(w_q);
   assign k_x = ext(k_q);
   assign s_x = ext(s_q);
   assign p_x = ext(p_q);

   // A tap transfers only in RUN, and abort pre-empts a coincident transfer.
   assign hs = (state_q == S_RUN) & tap_valid_q & bus.tap_ready & ~bus.abort;

   // Next scan position (initial position when leaving CHECK) and the tap fields it implies.
   always_comb begin
      cfg_bad   = (k_q == '0) | (s_q == '0) | (h_q == '0) | (w_q == '0) |
                  (k_x > h_x + p_x + p_x) | (k_x > w_x + p_x + p_x);
      kx_end    = (kx_q == k_q - 1'b1);
      ky_end    = (ky_q == k_q - 1'b1);
      col_ok    = (org_c_q + s_x + k_x) <= (w_x + p_x);
      row_ok    = (org_r_q + s_x + k_x) <= (h_x + p_x);
      final_tap = kx_end & ky_end & ~col_ok & ~row_ok;
      org_r_d   = org_r_q;
      org_c_d   = org_c_q;
      ky_d      = ky_q;
      kx_d      = kx_q;
      wr_d      = wr_q;
      wc_d      = wc_q;
      if (state_q == S_CHECK) begin
         org_r_d = -p_x;
         org_c_d = -p_x;
         ky_d    = '0;
         kx_d    = '0;
         wr_d    = '0;
         wc_d    = '0;
      end else if (!kx_end) begin
         kx_d = kx_q + 1'b1;
      end else begin
         kx_d = '0;
         if (!ky_end) begin
            ky_d = ky_q + 1'b1;
         end else begin
            ky_d = '0;
            if (col_ok) begin
               org_c_d = org_c_q + s_x;
               wc_d    = wc_q + 1'b1;
            end else begin
               org_c_d = -p_x;
               wc_d    = '0;
               if (row_ok) begin
                  org_r_d = org_r_q + s_x;
                  wr_d    = wr_q + 1'b1;
               end
            end
         end
      end
      row_d   = org_r_d + ext(ky_d);
      col_d   = org_c_d + ext(kx_d);
      pad_d   = row_d[CW-1] | (row_d >= h_x) | col_d[CW-1] | (col_d >= w_x);
      first_d = (ky_d == '0) & (kx_d == '0);
      last_d  = (ky_d == k_q - 1'b1) & (kx_d == k_q - 1'b1);
      wlast_d = ((org_c_d + s_x + k_x) > (w_x + p_x)) & ((org_r_d + s_x + k_x) > (h_x + p_x));
   end

   // Layer FSM with all outputs registered; abort wins over every non-IDLE transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         w_q         <= '0;
         k_q         <= '0;
         s_q         <= '0;
         p_q         <= '0;
         org_r_q     <= '0;
         org_c_q     <= '0;
         ky_q        <= '0;
         kx_q        <= '0;
         wr_q        <= '0;
         wc_q        <= '0;
         max_wc_q    <= '0;
         tap_valid_q <= 1'b0;
         tap_row_q   <= '0;
         tap_col_q   <= '0;
         pad_q       <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         wlast_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         oh_q        <= '0;
         ow_q        <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if ((state_q != S_IDLE) && bus.abort) begin
            state_q     <= S_IDLE;
            tap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.start) begin
                     h_q     <= bus.cfg_in_height;
                     w_q     <= bus.cfg_in_width;
                     k_q     <= bus.cfg_kernel_size;
                     s_q     <= bus.cfg_stride;
                     p_q     <= bus.cfg_padding;
                     busy_q  <= 1'b1;
                     state_q <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (cfg_bad) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     max_wc_q    <= '0;
                     tap_valid_q <= 1'b1;
                     state_q     <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (hs && final_tap) begin
                     tap_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     oh_q        <= wr_q + 1'b1;
                     ow_q        <= max_wc_q + 1'b1;
                     state_q     <= S_DONE;
                  end else if (hs && (wc_d > max_wc_q)) begin
                     max_wc_q <= wc_d;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
            // Position and tap fields move together: on entry to RUN and on each non-final transfer.
            if ((state_q == S_CHECK && !cfg_bad) || (hs && !final_tap)) begin
               org_r_q   <= org_r_d;
               org_c_q   <= org_c_d;
               ky_q      <= ky_d;
               kx_q      <= kx_d;
               wr_q      <= wr_d;
               wc_q      <= wc_d;
               tap_row_q <= row_d[DIM_W+1:0];
               tap_col_q <= col_d[DIM_W+1:0];
               pad_q     <= pad_d;
               first_q   <= first_d;
               last_q    <= last_d;
               wlast_q   <= wlast_d;
            end
         end
      end
   end

   assign bus.tap_valid  = tap_valid_q;
   assign bus.tap_row    = tap_row_q;
   assign bus.tap_col    = tap_col_q;
   assign bus.tap_pad    = pad_q;
   assign bus.tap_first  = first_q;
   assign bus.tap_last   = last_q;
   assign bus.win_row    = wr_q;
   assign bus.win_col    = wc_q;
   assign bus.win_last   = wlast_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.cfg_error  = err_q;
   assign bus.out_height = oh_q;
   assign bus.out_width  = ow_q;
   assign dbg_state_o    = state_q;

`ifdef CONV_SCHED_PERF_EN
   logic [31:0] perf_taps_q, perf_stalls_q, perf_pad_q;

   // Saturating activity counters, cleared on an accepted start and frozen outside RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_taps_q   <= '0;
         perf_stalls_q <= '0;
         perf_pad_q    <= '0;
      end else if (state_q == S_IDLE && bus.start) begin
         perf_taps_q   <= '0;
         perf_stalls_q <= '0;
         perf_pad_q    <= '0;
      end else if (state_q == S_RUN && !bus.abort) begin
         if (hs && perf_taps_q != '1)
            perf_taps_q <= perf_taps_q + 32'd1;
         if (hs && pad_q && perf_pad_q != '1)
            perf_pad_q <= perf_pad_q + 32'd1;
         if (tap_valid_q && !bus.tap_ready && perf_stalls_q != '1)
            perf_stalls_q <= perf_stalls_q + 32'd1;
      end
   end

   assign perf_taps   = perf_taps_q;
   assign perf_stalls = perf_stalls_q;
   assign perf_pad    = perf_pad_q;
`endif

endmodule
